// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU byte-bus target: 128KB RAM, UART TX/RX FIFOs, cycle counter, stop flag
// mem_din is registered (one-cycle read latency); tx_data falls through from the TX FIFO head.
module mem_io_responder #(
   parameter int RAM_AW     = 17,
   parameter int TX_DEPTH   = 16,
   parameter int RX_DEPTH   = 16,
   parameter int FULL_SLACK = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        prog_stop,
   output logic        tx_overflow
);
   localparam int TX_PW = $clog2(TX_DEPTH);
   localparam int RX_PW = $clog2(RX_DEPTH);
   localparam logic [17:0] A_UART = 18'h30000;
   localparam logic [17:0] A_CNT0 = 18'h30004;
   localparam logic [17:0] A_CNT1 = 18'h30005;
   localparam logic [17:0] A_CNT2 = 18'h30006;
   localparam logic [17:0] A_CNT3 = 18'h30007;
   localparam logic [TX_PW:0] TX_ONE    = (TX_PW+1)'(1);
   localparam logic [RX_PW:0] RX_ONE    = (RX_PW+1)'(1);
   localparam logic [TX_PW:0] TX_ZERO   = '0;
   localparam logic [TX_PW:0] TX_THRESH = (TX_PW+1)'(TX_DEPTH - FULL_SLACK);

   logic [7:0]        r_ram    [2**RAM_AW];
   logic [7:0]        r_tx_mem [TX_DEPTH];
   logic [7:0]        r_rx_mem [RX_DEPTH];
   logic [TX_PW:0]    r_tx_wr, r_tx_rd;
   logic [RX_PW:0]    r_rx_wr, r_rx_rd;
   logic [31:0]       r_cycle;
   logic [31:8]       r_snap;
   logic [7:0]        r_din;
   logic              r_full, r_stop, r_ovf;

   logic [17:0]       w_addr;
   logic [RAM_AW-1:0] w_ram_addr;
   logic              w_io, w_ram_wr, w_uart_wr, w_stop_wr, w_uart_rd, w_cnt_rd;
   logic              w_tx_empty, w_tx_full, w_tx_push_req, w_tx_push, w_tx_pop;
   logic              w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
   logic [7:0]        w_tx_push_data, w_rd_data;
   logic [TX_PW:0]    w_tx_count, w_tx_count_nxt;
   logic              w_unused;

   assign w_addr     = mem_a[17:0];
   assign w_ram_addr = mem_a[RAM_AW-1:0];
   assign w_unused   = &{1'b0, mem_a[31:18]};
   assign w_io       = (w_addr[17:16] == 2'b11);
   assign w_ram_wr   = mem_wr && !w_io;
   assign w_uart_wr  = mem_wr && (w_addr == A_UART);
   assign w_stop_wr  = mem_wr && (w_addr == A_CNT0);
   assign w_uart_rd  = !mem_wr && (w_addr == A_UART);
   assign w_cnt_rd   = !mem_wr && (w_addr == A_CNT0);

   // Full/empty from pointers one bit wider than the index: MSBs differ only after a wrap.
   assign w_tx_empty = (r_tx_wr == r_tx_rd);
   assign w_tx_full  = (r_tx_wr[TX_PW] != r_tx_rd[TX_PW]) &&
                       (r_tx_wr[TX_PW-1:0] == r_tx_rd[TX_PW-1:0]);
   assign w_rx_empty = (r_rx_wr == r_rx_rd);
   assign w_rx_full  = (r_rx_wr[RX_PW] != r_rx_rd[RX_PW]) &&
                       (r_rx_wr[RX_PW-1:0] == r_rx_rd[RX_PW-1:0]);

   // The stop write pushes a literal zero so the host sees the end of output.
   assign w_tx_push_req  = (w_uart_wr && (mem_dout != 8'h00)) || w_stop_wr;
   assign w_tx_push_data = w_stop_wr ? 8'h00 : mem_dout;
   assign w_tx_pop       = !w_tx_empty && tx_ready;
   assign w_tx_push      = w_tx_push_req && (!w_tx_full || w_tx_pop);
   assign w_tx_count     = r_tx_wr - r_tx_rd;
   assign w_tx_count_nxt = w_tx_count + (w_tx_push ? TX_ONE : TX_ZERO) - (w_tx_pop ? TX_ONE : TX_ZERO);

   assign w_rx_push = rx_valid && !w_rx_full;
   assign w_rx_pop  = w_uart_rd && !w_rx_empty;

   always_comb begin
      w_rd_data = 8'h00;
      if (!w_io) begin
         w_rd_data = r_ram[w_ram_addr];
      end else begin
         case (w_addr)
            A_UART:  if (!w_rx_empty) w_rd_data = r_rx_mem[r_rx_rd[RX_PW-1:0]];
            A_CNT0:  w_rd_data = r_cycle[7:0];
            A_CNT1:  w_rd_data = r_snap[15:8];
            A_CNT2:  w_rd_data = r_snap[23:16];
            A_CNT3:  w_rd_data = r_snap[31:24];
            default: w_rd_data = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_ram_wr)  r_ram[w_ram_addr] <= mem_dout;
      if (w_tx_push) r_tx_mem[r_tx_wr[TX_PW-1:0]] <= w_tx_push_data;
      if (w_rx_push) r_rx_mem[r_rx_wr[RX_PW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_tx_wr <= '0;
         r_tx_rd <= '0;
         r_rx_wr <= '0;
         r_rx_rd <= '0;
         r_cycle <= '0;
         r_snap  <= '0;
         r_din   <= '0;
         r_full  <= 1'b0;
         r_stop  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_tx_push) r_tx_wr <= r_tx_wr + TX_ONE;
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_ONE;
         if (w_rx_push) r_rx_wr <= r_rx_wr + RX_ONE;
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_ONE;
         if (w_tx_push_req && !w_tx_push) r_ovf <= 1'b1;
         if (w_stop_wr) r_stop <= 1'b1;
         if (w_cnt_rd)  r_snap <= r_cycle[31:8];
         if (!mem_wr)   r_din  <= w_rd_data;
         r_full <= (w_tx_count_nxt >= TX_THRESH);
      end
   end

   assign mem_din        = r_din;
   assign io_buffer_full = r_full;
   assign tx_valid       = !w_tx_empty;
   assign tx_data        = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd[TX_PW-1:0]];
   assign prog_stop      = r_stop;
   assign tx_overflow    = r_ovf;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder
// Queue/array model updated each rising edge, compared to the DUT on every falling edge.
module tb_mem_io_responder;
   localparam logic [31:0] IDLE_A = 32'h0003FFF0;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] mem_a = IDLE_A;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_dout = 8'h00;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        prog_stop;
   logic        tx_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   mem_io_responder dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
      .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .prog_stop(prog_stop),
      .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   // Reference model state
   bit   [7:0]  m_ram [int];
   logic [7:0]  m_txq [$];
   logic [7:0]  m_rxq [$];
   logic [7:0]  m_tx_log [$];
   logic [7:0]  m_din;
   bit          m_din_known;
   logic [31:0] m_cycle, m_snap;
   bit          m_full, m_stop, m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_txq.delete();
      m_rxq.delete();
      m_din = 8'h00;
      m_din_known = 1'b1;
      m_cycle = 32'd0;
      m_snap = 32'd0;
      m_full = 1'b0;
      m_stop = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic m_step();
      logic [17:0] a;
      bit          io, pop, push_req;
      logic [7:0]  pd;
      int          rx_n, ra;
      a    = mem_a[17:0];
      io   = (a >= 18'h30000);
      ra   = int'(a[16:0]);
      rx_n = m_rxq.size();
      pop  = (m_txq.size() != 0) && tx_ready;
      push_req = 1'b0;
      pd = mem_dout;
      if (mem_wr) begin
         if (!io) m_ram[ra] = mem_dout;
         else if (a == 18'h30000) push_req = (mem_dout != 8'h00);
         else if (a == 18'h30004) begin
            push_req = 1'b1;
            pd = 8'h00;
            m_stop = 1'b1;
         end
      end else if (!io) begin
         m_din_known = m_ram.exists(ra);
         if (m_din_known) m_din = m_ram[ra];
      end else begin
         m_din_known = 1'b1;
         case (a)
            18'h30000: m_din = (rx_n != 0) ? m_rxq.pop_front() : 8'h00;
            18'h30004: begin m_snap = m_cycle; m_din = m_cycle[7:0]; end
            18'h30005: m_din = m_snap[15:8];
            18'h30006: m_din = m_snap[23:16];
            18'h30007: m_din = m_snap[31:24];
            default:   m_din = 8'h00;
         endcase
      end
      if (rx_valid && rx_n < 16) m_rxq.push_back(rx_data);
      if (pop) m_tx_log.push_back(m_txq.pop_front());
      if (push_req) begin
         if (m_txq.size() < 16) m_txq.push_back(pd);
         else m_ovf = 1'b1;
      end
      m_full  = (m_txq.size() >= 14);
      m_cycle = m_cycle + 32'd1;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk_in or posedge rst_in);
         if (rst_in) m_reset();
         else m_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk_in);
         if (m_din_known) check("mem_din", mem_din, m_din);
         check("tx_valid", tx_valid, m_txq.size() != 0);
         if (m_txq.size() != 0) check("tx_data", tx_data, m_txq[0]);
         check("io_buffer_full", io_buffer_full, m_full);
         check("prog_stop", prog_stop, m_stop);
         check("tx_overflow", tx_overflow, m_ovf);
      end
   end

   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic rdy, input logic rxv, input logic [7:0] rxd);
      @(negedge clk_in);
      #1;
      mem_a = a; mem_wr = wr; mem_dout = d;
      tx_ready = rdy; rx_valid = rxv; rx_data = rxd;
   endtask

   task automatic idle(input logic rdy);
      drive(IDLE_A, 1'b0, 8'h00, rdy, 1'b0, 8'h00);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " mem_din"}, mem_din, 0);
      check({tag, " tx_data"}, tx_data, 0);
      check({tag, " tx_valid"}, tx_valid, 0);
      check({tag, " io_buffer_full"}, io_buffer_full, 0);
      check({tag, " prog_stop"}, prog_stop, 0);
      check({tag, " tx_overflow"}, tx_overflow, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk_in);
      #1;
      mem_a = IDLE_A; mem_wr = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
      rst_in = 1'b1;
      @(negedge clk_in);
      #1;
      rst_in = 1'b0;
   endtask

   logic [31:0] pool [6] = '{32'h00010, 32'h1FFFF, 32'h10000, 32'h0ABCD, 32'h20005, 32'h00005};
   logic [7:0]  b [4];

   initial begin
      #1 rst_in = 1'b1;
      repeat (2) @(negedge clk_in);
      #1;
      check_all_zero("reset");
      rst_in = 1'b0;

      // RAM write then read: one-cycle latency
      drive(32'h00010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
      drive(32'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      idle(1'b0);
      check("t1 ram 0x10", mem_din, 8'hA5);

      // Top RAM byte, then 0x20000 must not touch I/O
      drive(32'h1FFFF, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
      drive(32'h1FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      idle(1'b0);
      check("t2 ram 0x1FFFF", mem_din, 8'h3C);
      drive(32'h20000, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
      idle(1'b0);
      check("t2 no tx push", tx_valid, 0);
      check("t2 no stop", prog_stop, 0);

      // Zero byte filtered from the TX stream
      m_tx_log.delete();
      drive(32'h30000, 1'b1, 8'h48, 1'b1, 1'b0, 8'h00);
      drive(32'h30000, 1'b1, 8'h69, 1'b1, 1'b0, 8'h00);
      drive(32'h30000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
      repeat (3) idle(1'b1);
      check("t3 tx count", m_tx_log.size(), 2);
      if (m_tx_log.size() == 2) begin
         check("t3 tx byte0", m_tx_log[0], 8'h48);
         check("t3 tx byte1", m_tx_log[1], 8'h69);
      end
      check("t3 tx empty", tx_valid, 0);

      // Near-full threshold, overflow, ordered drain
      for (int i = 1; i <= 13; i++) drive(32'h30000, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
      idle(1'b0);
      check("t4 full after 13", io_buffer_full, 0);
      drive(32'h30000, 1'b1, 8'h1E, 1'b0, 1'b0, 8'h00);
      idle(1'b0);
      check("t4 full after 14", io_buffer_full, 1);
      for (int i = 15; i <= 17; i++) drive(32'h30000, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
      idle(1'b0);
      check("t4 overflow", tx_overflow, 1);
      check("t4 head", tx_data, 8'h11);
      m_tx_log.delete();
      repeat (18) idle(1'b1);
      check("t4 drained count", m_tx_log.size(), 16);
      for (int j = 0; j < m_tx_log.size(); j++) check("t4 drain order", m_tx_log[j], 8'(8'h11 + j));

      // RX FIFO: two bytes, then empty read, then push+pop on empty
      drive(IDLE_A, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31);
      drive(IDLE_A, 1'b0, 8'h00, 1'b0, 1'b1, 8'h32);
      drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      check("t5 rx 1st", mem_din, 8'h31);
      drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      check("t5 rx 2nd", mem_din, 8'h32);
      drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
      check("t5 rx empty", mem_din, 8'h00);
      drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      check("t5 pop on empty", mem_din, 8'h00);
      idle(1'b0);
      check("t5 stored not forwarded", mem_din, 8'h5A);

      // Randomized traffic, with occasional resets mid-stream
      for (int i = 0; i < 2000; i++) begin
         logic [13:0] hi;
         logic [17:0] a;
         logic [7:0]  d;
         logic        wr, rdy, rxv;
         int          op;
         if ($urandom_range(0, 299) == 0) begin
            idle(1'b0);
            rst_in = 1'b1;
         end else begin
            hi  = 14'($urandom);
            op  = $urandom_range(0, 19);
            d   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d = 8'h00;
            rdy = ($urandom_range(0, 99) < ((i < 1000) ? 15 : 60));
            rxv = ($urandom_range(0, 3) == 0);
            wr  = 1'b0;
            a   = 18'h3FFF0;
            if (op < 4)       begin a = pool[$urandom_range(0, 5)][17:0]; wr = 1'b1; end
            else if (op < 8)  a = pool[$urandom_range(0, 5)][17:0];
            else if (op < 12) begin a = 18'h30000; wr = 1'b1; end
            else if (op < 15) a = 18'h30000;
            else if (op < 18) a = 18'(18'h30004 + $urandom_range(0, 3));
            else if (op == 18) begin a = ($urandom_range(0, 1) != 0) ? 18'h30001 : 18'h3FFF0; wr = 1'(($urandom_range(0, 1))); end
            else if ($urandom_range(0, 3) == 0) begin a = 18'h30004; wr = 1'b1; end
            drive({hi, a}, wr, d, rdy, rxv, 8'($urandom_range(0, 255)));
            rst_in = 1'b0;
         end
      end
      rst_in = 1'b0;

      // Cycle snapshot after 0x100 edges from reset, then stop write and reset
      pulse_reset();
      repeat (255) idle(1'b0);
      drive(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      drive(32'h30005, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      b[0] = mem_din;
      drive(32'h30006, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      b[1] = mem_din;
      drive(32'h30007, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      b[2] = mem_din;
      idle(1'b0);
      b[3] = mem_din;
      check("t6 snapshot", {b[3], b[2], b[1], b[0]}, 32'h00000100);
      check("t6 model snapshot", m_snap, 32'h00000100);
      drive(32'h30004, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
      idle(1'b0);
      check("t6 prog_stop", prog_stop, 1);
      check("t6 tx_valid", tx_valid, 1);
      check("t6 tx_data", tx_data, 8'h00);
      rst_in = 1'b1;
      #1;
      check_all_zero("async reset");
      @(negedge clk_in);
      #1;
      rst_in = 1'b0;
      idle(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
